// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer definitions.
// Gray/binary helpers are reused by the write-side full block.
package fifo_pkg;

  localparam int ADDR_WIDTH = 3;
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary conversion (XOR prefix from the MSB).
// Shared by both pointer domains.
module gray2bin_conv #(
  parameter int width = 4
) (
  input  logic [width-1:0] gray,
  output logic [width-1:0] bin
);

  for (genvar i = 0; i < width; i++) begin : g_bit
    assign bin[i] = ^gray[width-1:i];
  end

endmodule

// File: rtl/rptr_empty_gray.sv
// Read-side pointer, empty/almost-empty flags and fill level.
// Optional macro RPTR_UFLOW_FLAG_EN adds a sticky underflow flag ruflow.
module rptr_empty_gray
  import fifo_pkg::*;
#(
  parameter int addr_width    = ADDR_WIDTH,
  parameter int aempty_thresh = 1
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rinc,
  input  logic [addr_width:0]   rq2_wptr,
  output logic [addr_width:0]   rptr,
  output logic [addr_width-1:0] raddr,
  output logic                  rpop,
`ifdef RPTR_UFLOW_FLAG_EN
  output logic                  ruflow,
`endif
  output logic                  rempty,
  output logic                  raempty,
  output logic [addr_width:0]   rlevel
);

  localparam int PW = addr_width + 1;
  localparam logic [PW-1:0] THR = PW'(aempty_thresh);

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wbin;
  logic [PW-1:0] lvl_next;

  gray2bin_conv #(
    .width (PW)
  ) u_wconv (
    .gray (rq2_wptr),
    .bin  (wbin)
  );

  assign rpop       = rinc & ~rempty;
  assign rbin_next  = rbin + {{(PW-1){1'b0}}, rpop};
  assign rgray_next = PW'(bin2gray(32'(rbin_next)));
  // Level uses the post-pop pointer so flags carry no extra lag.
  assign lvl_next   = wbin - rbin_next;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin    <= '0;
      rptr    <= '0;
      raddr   <= '0;
      rempty  <= 1'b1;
      raempty <= 1'b1;
      rlevel  <= '0;
    end else begin
      rbin    <= rbin_next;
      rptr    <= rgray_next;
      raddr   <= rbin_next[addr_width-1:0];
      rempty  <= (rgray_next == rq2_wptr);
      raempty <= (lvl_next <= THR);
      rlevel  <= lvl_next;
    end
  end

`ifdef RPTR_UFLOW_FLAG_EN
  always_ff @(posedge rclk) begin
    if (rrst) begin
      ruflow <= 1'b0;
    end else if (rinc && rempty) begin
      ruflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rptr_empty_gray.sv
// Directed bench for rptr_empty_gray (addr_width=3, aempty_thresh=1).
// Underflow-flag steps run only when RPTR_UFLOW_FLAG_EN is defined.
module tb_rptr_empty_gray;

  logic       rclk = 1'b0;
  logic       rrst = 1'b1;
  logic       rinc = 1'b0;
  logic [3:0] rq2_wptr = 4'd0;
  logic [3:0] rptr;
  logic [2:0] raddr;
  logic       rpop;
  logic       rempty;
  logic       raempty;
  logic [3:0] rlevel;
`ifdef RPTR_UFLOW_FLAG_EN
  logic       ruflow;
`endif

  int checks = 0;
  int errors = 0;

  always #5 rclk = ~rclk;

  rptr_empty_gray #(
    .addr_width    (3),
    .aempty_thresh (1)
  ) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .rinc     (rinc),
    .rq2_wptr (rq2_wptr),
    .rptr     (rptr),
    .raddr    (raddr),
    .rpop     (rpop),
`ifdef RPTR_UFLOW_FLAG_EN
    .ruflow   (ruflow),
`endif
    .rempty   (rempty),
    .raempty  (raempty),
    .rlevel   (rlevel)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] p,
                         input logic [2:0] a, input logic e,
                         input logic ae, input logic [3:0] l);
    chk({tag, ".rptr"}, 32'(rptr), 32'(p));
    chk({tag, ".raddr"}, 32'(raddr), 32'(a));
    chk({tag, ".rempty"}, 32'(rempty), 32'(e));
    chk({tag, ".raempty"}, 32'(raempty), 32'(ae));
    chk({tag, ".rlevel"}, 32'(rlevel), 32'(l));
  endtask

  initial begin
    // 1: reset, then read request while empty
    rrst = 1'b1; rinc = 1'b1;
    tick();
    chk("rst_rpop0", 32'(rpop), 0);
    tick();
    chk_all("rst", 4'd0, 3'd0, 1'b1, 1'b1, 4'd0);
    chk("rst_rpop1", 32'(rpop), 0);
    rrst = 1'b0; rq2_wptr = 4'd0; rinc = 1'b1;
    #1;
    chk("idle_rpop", 32'(rpop), 0);
    tick();
    chk_all("idle", 4'd0, 3'd0, 1'b1, 1'b1, 4'd0);

    // 2: fill to three, then drain
    rinc = 1'b0; rq2_wptr = 4'b0001;
    tick();
    chk_all("fill1", 4'd0, 3'd0, 1'b0, 1'b1, 4'd1);
    rq2_wptr = 4'b0011;
    tick();
    chk_all("fill2", 4'd0, 3'd0, 1'b0, 1'b0, 4'd2);
    rq2_wptr = 4'b0010;
    tick();
    chk_all("fill3", 4'd0, 3'd0, 1'b0, 1'b0, 4'd3);
    rinc = 1'b1;
    #1;
    chk("pop1_rpop", 32'(rpop), 1);
    tick();
    chk_all("pop1", 4'b0001, 3'd1, 1'b0, 1'b0, 4'd2);
    tick();
    chk_all("pop2", 4'b0011, 3'd2, 1'b0, 1'b1, 4'd1);
    tick();
    chk_all("pop3", 4'b0010, 3'd3, 1'b1, 1'b1, 4'd0);
    chk("pop4_rpop", 32'(rpop), 0);
    tick();
    chk_all("pop4", 4'b0010, 3'd3, 1'b1, 1'b1, 4'd0);

    // 3: full FIFO and wrap-around
    rinc = 1'b0; rrst = 1'b1;
    tick();
    rrst = 1'b0; rq2_wptr = 4'b1100;
    tick();
    chk_all("full", 4'd0, 3'd0, 1'b0, 1'b0, 4'd8);
    rinc = 1'b1;
    repeat (8) tick();
    chk_all("wrap8", 4'b1100, 3'd0, 1'b1, 1'b1, 4'd0);
    rinc = 1'b0; rq2_wptr = 4'b0000;
    tick();
    chk_all("full2", 4'b1100, 3'd0, 1'b0, 1'b0, 4'd8);
    rinc = 1'b1;
    repeat (8) tick();
    chk_all("wrap16", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0);

    // 4: pop and write advance in the same cycle
    rinc = 1'b0; rq2_wptr = 4'b0011;
    tick();
    chk_all("sim_pre", 4'd0, 3'd0, 1'b0, 1'b0, 4'd2);
    rinc = 1'b1; rq2_wptr = 4'b0010;
    tick();
    chk_all("sim", 4'b0001, 3'd1, 1'b0, 1'b0, 4'd2);

    // 5: reset while popping at level 5
    rinc = 1'b0; rq2_wptr = 4'b0101;
    tick();
    chk_all("lvl5", 4'b0001, 3'd1, 1'b0, 1'b0, 4'd5);
    rinc = 1'b1; rrst = 1'b1;
    tick();
    chk_all("midrst", 4'd0, 3'd0, 1'b1, 1'b1, 4'd0);
    rrst = 1'b0; rinc = 1'b0; rq2_wptr = 4'b0000;
    tick();
    chk_all("postrst", 4'd0, 3'd0, 1'b1, 1'b1, 4'd0);

`ifdef RPTR_UFLOW_FLAG_EN
    // 6: sticky underflow flag
    chk("uf_clear", 32'(ruflow), 0);
    rinc = 1'b1;
    tick();
    chk("uf_set", 32'(ruflow), 1);
    rinc = 1'b0; rq2_wptr = 4'b0011;
    tick();
    rinc = 1'b1;
    tick();
    chk("uf_pop1", 32'(ruflow), 1);
    tick();
    chk("uf_pop2", 32'(ruflow), 1);
    chk_all("uf_drain", 4'b0011, 3'd2, 1'b1, 1'b1, 4'd0);
    rinc = 1'b0; rrst = 1'b1;
    tick();
    chk("uf_rst", 32'(ruflow), 0);
    rrst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rptr_empty_gray.md
Name: rptr_empty_gray

Overview:
- Read-side pointer and status block for the async FIFO, and the parametrised successor to the plain binary read-pointer/empty logic.
- Keeps a binary read pointer and its Gray-coded twin. Compares the twin against the write pointer, which arrives Gray-coded through the 2-flop synchroniser.
- Produces registered empty, almost-empty and fill-level outputs.
- Sits in the read clock domain between the wptr synchroniser and the dual-port RAM read address.

Parameters:
- addr_width, 3, RAM address bits; depth = 2**addr_width; pointers are addr_width+1 bits.
- aempty_thresh, 1, raempty asserts when fill level <= this value; legal range 0..2**addr_width-1.

Ports:
- rclk  input  1  read-domain clock.
- rrst  input  1  synchronous, active-high reset.
- rinc  input  1  read request from consumer.
- rq2_wptr  input  addr_width+1  write pointer, Gray-coded, already synchronised into rclk.
- rptr  output  addr_width+1  Gray-coded read pointer, registered, sent to the write-domain synchroniser.
- raddr  output  addr_width  RAM read address = low addr_width bits of the binary pointer, registered.
- rpop  output  1  read accepted this cycle = rinc & ~rempty, combinational.
- rempty  output  1  FIFO empty, registered.
- raempty  output  1  fill level <= aempty_thresh, registered.
- rlevel  output  addr_width+1  entries available to read (0..depth), registered.

Behaviour:
- Reset (rrst=1 at a rclk edge): rbin=0, rptr=0, raddr=0, rempty=1, raempty=1, rlevel=0. Reset has priority over rinc.
- Reset mid-operation discards pointer state in one cycle.
- rpop is forced 0 while rempty=1. rempty is 1 during reset, so rpop is 0 then.
- Next-state logic:
  - rbin_next = rbin + rpop, modulo 2**(addr_width+1). Wraps from all-ones to 0.
  - rgray_next = rbin_next ^ (rbin_next >> 1).
- Registered each cycle: rbin<=rbin_next, rptr<=rgray_next, raddr<=rbin_next[addr_width-1:0].
  - raddr therefore always matches rptr, with no extra lag cycle.
- Fill-level and flag logic:
  - wbin = gray2bin(rq2_wptr).
  - rlevel <= wbin - rbin_next, in addr_width+1-bit modulo arithmetic.
  - rempty <= (rgray_next == rq2_wptr).
  - raempty <= (wbin - rbin_next) <= aempty_thresh.
- Latency:
  - A pop at edge N is reflected in rptr, raddr, rlevel and rempty after edge N.
  - A change on rq2_wptr at edge N is reflected in flags after edge N+1.
- Simultaneous pop and rq2_wptr advance: both enter the same next-state computation; level = new wbin - rbin_next.
- Full FIFO: rlevel = depth (MSB set, low bits 0). Pointers differ only in the top two Gray bits. rempty=0.
- Wrap-around: rptr MSB toggles once per depth pops. Empty detection stays correct across any number of wraps.
- rinc while empty: ignored. Pointer and level are held, and the RAM is not addressed forward.
- Illegal input (wbin - rbin > depth) is out of contract. Outputs follow the arithmetic above and are not checked.

Optional Feature:
- Macro: RPTR_UFLOW_FLAG_EN.
- Defined:
  - Extra output ruflow (1 bit, registered, sticky).
  - Set on the edge after any cycle with rinc=1 && rempty=1.
  - Cleared only by rrst; reset value 0.
- Undefined: port ruflow is absent. Read-while-empty is silently ignored. All other behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - default ADDR_WIDTH constant;
  - pointer width helper (ADDR_WIDTH+1);
  - functions bin2gray and gray2bin, also used by the write-side full block.
- One sub-module, gray2bin_conv (parametrised width, purely combinational XOR-prefix), instantiated for wbin.
  - Kept as a module so the write side can reuse it on rq2_rptr.

Test Plan:
All scenarios use addr_width=3, aempty_thresh=1.
1. Reset check: hold rrst 2 cycles, then rrst=0 with rq2_wptr=0 and rinc=1. Required: rempty=1, raempty=1, rlevel=0, rptr=0, raddr=0, rpop=0 throughout.
2. Fill then drain: step rq2_wptr Gray 0→1→3→2 (wbin 3).
   - rlevel goes 1,2,3; raempty deasserts at level 2; rempty deasserts one cycle after the first step.
   - Then rinc=1 for 3 cycles: raddr 1,2,3; rptr 1,3,2; rlevel 2,1,0; raempty reasserts at level 1; rempty=1 after the third pop.
   - Fourth rinc: rpop=0 and the pointer holds.
3. Full and wrap: rq2_wptr=Gray(8)=4'b1100 with rptr=0. rlevel=8, rempty=0. Then 8 pops give rptr=4'b1100, raddr=0, rempty=1. Repeat to Gray(16 mod 16)=0 to confirm wrap.
4. Simultaneous: at level 2, pop in the same cycle rq2_wptr advances by one. Required: rlevel stays 2; rempty and raempty stay 0.
5. Mid-operation reset: at level 5 with rinc=1, assert rrst one cycle. Required: all outputs return to reset values at that edge; no pop is counted.
6. RPTR_UFLOW_FLAG_EN defined: rinc=1 while empty. Required: ruflow=1 next cycle and stays 1 through later normal pops; it clears only on rrst.
